pwm_generator: RTL and testbench

//   Consumes the five configuration registers written by the SPI register

---
 rtl/pwm_if.sv | 20 ++
 rtl/pwm_generator.sv | 51 +++++
 tb/tb_pwm_generator.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pwm_if.sv
// pwm_if: configuration registers from the SPI register block plus the PWM outputs
//   master (register source): drives en_reg_out_*, en_reg_pwm_*, pwm_duty_cycle; reads out, period_start
//   slave  (pwm_generator):   reads the registers; drives out (16 pins) and period_start (wrap pulse)
interface pwm_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;
  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out, period_start
  );
  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_generator.sv
// pwm_generator: 16 outputs, each off, static high or PWM at a shared 8-bit duty
//   clk  system clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  pwm_if.slave: enable/PWM-select/duty registers in, registered out[15:0] and period_start out
//   CLK_DIV  clocks per PWM counter step, PWM period = CLK_DIV*256 clocks
//   Optional macro PWM_SHADOW_EN: duty is shadowed and only updated at the period boundary.
module pwm_generator #(
  parameter int CLK_DIV = 13
) (
  input  logic clk,
  input  logic rst,
  pwm_if.slave bus
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [PW-1:0] prescaler;
  logic [7:0]    pwm_cnt;
  logic [7:0]    duty_eff;
  logic [15:0]   en_out;
  logic [15:0]   en_pwm;
  logic          tick;
  logic          wrap;
  logic          pwm_sig;
  assign en_out  = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm  = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
  assign tick    = prescaler == PW'(CLK_DIV - 1);
  assign wrap    = tick && pwm_cnt == 8'hFF;
  // 8'hFF is treated as a true 100% rather than 255/256
  assign pwm_sig = duty_eff == 8'hFF ? 1'b1 : pwm_cnt < duty_eff;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prescaler        <= '0;
      pwm_cnt          <= '0;
      bus.out          <= '0;
      bus.period_start <= 1'b0;
    end else begin
      prescaler        <= tick ? '0 : prescaler + PW'(1);
      pwm_cnt          <= pwm_cnt + 8'(tick);
      bus.period_start <= wrap;
      // enable wins over PWM select; selected bits follow pwm_sig, the rest are static high
      bus.out          <= en_out & (~en_pwm | {16{pwm_sig}});
    end
`ifdef PWM_SHADOW_EN
  logic [7:0] duty_shadow;
  always_ff @(posedge clk or posedge rst)
    if (rst) duty_shadow <= '0;
    else if (wrap) duty_shadow <= bus.pwm_duty_cycle;
  assign duty_eff = duty_shadow;
`else
  assign duty_eff = bus.pwm_duty_cycle;
`endif
endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: self-checking bench for pwm_generator (CLK_DIV=13 and CLK_DIV=1 instances)
module tb_pwm_generator;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  pwm_if bus();
  pwm_if bus2();
  pwm_generator #(.CLK_DIV(13)) dut  (.clk(clk), .rst(rst), .bus(bus));
  pwm_generator #(.CLK_DIV(1))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: after k clock edges since reset, the counter value is (k / CLK_DIV) mod 256.
  function automatic logic [15:0] model_out(int cnt, int duty, logic [15:0] eo, logic [15:0] ep);
    logic [15:0] r;
    logic sig;
    sig = (duty == 255) || (cnt < duty);
    for (int i = 0; i < 16; i++) r[i] = !eo[i] ? 1'b0 : (ep[i] ? sig : 1'b1);
    return r;
  endfunction

  int k1 = 0, k2 = 0, sh1 = 0, sh2 = 0;
  logic [15:0] e_out1 = '0, e_out2 = '0;
  logic e_ps1 = 1'b0, e_ps2 = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k1 <= 0; sh1 <= 0; e_out1 <= '0; e_ps1 <= 1'b0;
      k2 <= 0; sh2 <= 0; e_out2 <= '0; e_ps2 <= 1'b0;
    end else begin
`ifdef PWM_SHADOW_EN
      e_out1 <= model_out((k1 / 13) % 256, sh1, {bus.en_reg_out_15_8, bus.en_reg_out_7_0},
                          {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0});
      e_out2 <= model_out(k2 % 256, sh2, {bus2.en_reg_out_15_8, bus2.en_reg_out_7_0},
                          {bus2.en_reg_pwm_15_8, bus2.en_reg_pwm_7_0});
`else
      e_out1 <= model_out((k1 / 13) % 256, int'(bus.pwm_duty_cycle), {bus.en_reg_out_15_8, bus.en_reg_out_7_0},
                          {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0});
      e_out2 <= model_out(k2 % 256, int'(bus2.pwm_duty_cycle), {bus2.en_reg_out_15_8, bus2.en_reg_out_7_0},
                          {bus2.en_reg_pwm_15_8, bus2.en_reg_pwm_7_0});
`endif
      k1 <= k1 + 1;
      k2 <= k2 + 1;
      e_ps1 <= (k1 + 1) % 3328 == 0;
      e_ps2 <= (k2 + 1) % 256 == 0;
      if ((k1 + 1) % 3328 == 0) sh1 <= int'(bus.pwm_duty_cycle);
      if ((k2 + 1) % 256 == 0) sh2 <= int'(bus2.pwm_duty_cycle);
    end
  end

  always @(negedge clk) begin
    chk("out_div13", bus.out, e_out1);
    chk("ps_div13", 16'(bus.period_start), 16'(e_ps1));
    chk("out_div1", bus2.out, e_out2);
    chk("ps_div1", 16'(bus2.period_start), 16'(e_ps2));
  end

  typedef struct {
    logic [15:0] eo;
    logic [15:0] ep;
    logic [7:0]  duty;
    logic [15:0] exp_start;
    logic [15:0] exp_end;
  } vec_t;
  vec_t vecs[6];

  task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    {bus.en_reg_out_15_8, bus.en_reg_out_7_0} = eo;
    {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0} = ep;
    bus.pwm_duty_cycle = d;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hi, ps, hi2, w;
    vecs[0] = '{16'hFFFF, 16'hFFFF, 8'h00, 16'h0000, 16'h0000};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 8'hFF, 16'hFFFF, 16'hFFFF};
    vecs[2] = '{16'h00F0, 16'h0030, 8'h40, 16'h00F0, 16'h00C0};
    vecs[3] = '{16'hA5A5, 16'h0F0F, 8'h80, 16'hA5A5, 16'hA0A0};
    vecs[4] = '{16'hFFFF, 16'h0000, 8'h00, 16'hFFFF, 16'hFFFF};
    vecs[5] = '{16'h0000, 16'hFFFF, 8'hFF, 16'h0000, 16'h0000};
    set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
    bus2.en_reg_out_7_0 = 8'hFF; bus2.en_reg_out_15_8 = 8'hFF;
    bus2.en_reg_pwm_7_0 = 8'hFF; bus2.en_reg_pwm_15_8 = 8'hFF;
    bus2.pwm_duty_cycle = 8'h03;
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_out", bus.out, 16'h0000);
    chk("reset_ps", 16'(bus.period_start), 16'h0000);
    rst = 1'b0;
    // half duty at 13 clk/step, 3/256 at 1 clk/step; measure the second period of each
    hi = 0; ps = 0; hi2 = 0;
    for (int n = 1; n <= 6656; n++) begin
      @(negedge clk);
      if (n > 3328 && bus.out == 16'hFFFF) hi++;
      if (n > 3328 && bus.period_start) ps++;
      if (n > 256 && n <= 512 && bus2.out[0]) hi2++;
    end
    chk("half_duty_high_clks", 16'(hi), 16'd1664);
    chk("period_start_count", 16'(ps), 16'd1);
    chk("div1_duty3_high_clks", 16'(hi2), 16'd3);
    // mid-period duty change at pwm_cnt=100
    bus.pwm_duty_cycle = 8'h20;
    repeat (3328 + 1305) @(negedge clk);
    chk("duty20_cnt100", bus.out, 16'h0000);
    bus.pwm_duty_cycle = 8'hC0;
    @(negedge clk);
`ifdef PWM_SHADOW_EN
    chk("duty_change_held", bus.out, 16'h0000);
`else
    chk("duty_change_next_clk", bus.out, 16'hFFFF);
`endif
    for (w = 0; w < 4000 && !bus.period_start; w++) @(negedge clk);
    chk("wrap_wait_bounded", 16'(w < 4000), 16'd1);
    hi = 0;
    repeat (3328) begin
      @(negedge clk);
      if (bus.out == 16'hFFFF) hi++;
    end
    chk("duty_c0_high_clks", 16'(hi), 16'd2496);
    // async reset at pwm_cnt=200 while outputs are static high
    set_cfg(16'hFFFF, 16'h0000, 8'hC0);
    repeat (200 * 13 + 3) @(negedge clk);
    chk("static_high_cnt200", bus.out, 16'hFFFF);
    #2 rst = 1'b1;
    #1 chk("async_reset_out", bus.out, 16'h0000);
    chk("async_reset_ps", 16'(bus.period_start), 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
    for (w = 1; w <= 4000; w++) begin
      @(negedge clk);
      if (bus.period_start) break;
    end
    chk("first_period_after_reset", 16'(w), 16'd3328);
    // static configurations: out at pwm_cnt=0 and pwm_cnt=255 of the second period
    foreach (vecs[v]) begin
      @(negedge clk);
      set_cfg(vecs[v].eo, vecs[v].ep, vecs[v].duty);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3331) @(negedge clk);
      chk($sformatf("vec%0d_cnt0", v), bus.out, vecs[v].exp_start);
      repeat (3319) @(negedge clk);
      chk($sformatf("vec%0d_cnt255", v), bus.out, vecs[v].exp_end);
    end
    // random register traffic against the reference model
    repeat (5000) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0)
        set_cfg(16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      if ($urandom_range(0, 29) == 0) bus2.pwm_duty_cycle = 8'($urandom);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
